// File: rtl/pc_fetch_seq_pkg.sv
// Shared definitions for the instruction-fetch sequencer: state encoding,
// default reset vector and the sequential PC increment.
package pc_fetch_seq_pkg;

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_FETCH = 2'd1,
    S_VALID = 2'd2
  } state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_INC           = 32'd4;

endpackage

// File: rtl/pc_fetch_seq_adder.sv
// Plain modulo adder used for the sequential PC increment.
module pc_fetch_seq_adder #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/pc_fetch_seq.sv
// Instruction-fetch sequencer: issues one memory request per PC, holds the
// returned word for downstream, and follows branch redirects.
module pc_fetch_seq
  import pc_fetch_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_redirect,
  input  logic [31:0] i_nextpc,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_data,
  output logic        o_instr_valid,
  input  logic        i_instr_ready,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc
);

  state_t      state, next_state;
  logic [31:0] pc, pc_plus4, target, instr, instr_pc, redirect_pc;
  logic        kill, fetch_ack, drop;

  assign redirect_pc = i_nextpc & ~32'h0000_0003;
  assign fetch_ack   = (state == S_FETCH) && i_imem_ack;
  // A fetch returning while a redirect is pending or arriving is stale.
  assign drop        = kill || i_redirect;

  pc_fetch_seq_adder #(.WIDTH(32)) u_inc (
    .a   (pc),
    .b   (PC_INC),
    .sum (pc_plus4)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= S_RESET;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_RESET: next_state = S_FETCH;
      S_FETCH: if (fetch_ack && !drop) next_state = S_VALID;
      S_VALID: if (i_redirect || i_instr_ready) next_state = S_FETCH;
      default: next_state = S_RESET;
    endcase
  end

  always_comb begin
    o_imem_req    = (state == S_FETCH);
    o_instr_valid = (state == S_VALID);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pc       <= RESET_PC;
      target   <= '0;
      kill     <= 1'b0;
      instr    <= '0;
      instr_pc <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (fetch_ack) begin
            if (drop) begin
              pc   <= i_redirect ? redirect_pc : target;
              kill <= 1'b0;
            end else begin
              instr    <= i_imem_data;
              instr_pc <= pc;
            end
          end else if (i_redirect) begin
            // Address stays on the bus until ack; only remember where to go.
            kill   <= 1'b1;
            target <= redirect_pc;
          end
        end
        S_VALID: begin
          if (i_redirect)         pc <= redirect_pc;
          else if (i_instr_ready) pc <= pc_plus4;
        end
        default: ;
      endcase
    end
  end

  assign o_imem_addr = pc;
  assign o_instr     = instr;
  assign o_pc        = instr_pc;

endmodule

// File: tb/tb_pc_fetch_seq.sv
// Directed bench for pc_fetch_seq with hand-computed expected addresses.
module tb_pc_fetch_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] nextpc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_data = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] pc_out;

  int checks = 0;
  int errors = 0;
  int xfer_count = 0;
  logic [31:0] last_xfer_pc = '0;

  pc_fetch_seq #(.RESET_PC(32'h0000_0000)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_redirect    (redirect),
    .i_nextpc      (nextpc),
    .o_imem_req    (imem_req),
    .o_imem_addr   (imem_addr),
    .i_imem_ack    (imem_ack),
    .i_imem_data   (imem_data),
    .o_instr_valid (instr_valid),
    .i_instr_ready (instr_ready),
    .o_instr       (instr),
    .o_pc          (pc_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (instr_valid && instr_ready) begin
      xfer_count   <= xfer_count + 1;
      last_xfer_pc <= pc_out;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ack_with(input logic [31:0] data);
    imem_ack  = 1'b1;
    imem_data = data;
    step();
    imem_ack  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    checks++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl got req=%b valid=%b exp 0 0", imem_req, instr_valid);
    end
    checks++;
    if (imem_addr !== 32'h0 || pc_out !== 32'h0 || instr !== 32'h0) begin
      errors++; $display("FAIL reset_data got addr=%h pc=%h instr=%h exp all 0", imem_addr, pc_out, instr);
    end
    rst = 1'b0;
    step();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++; $display("FAIL first_req got req=%b addr=%h exp 1 00000000", imem_req, imem_addr);
    end
  endtask

  task automatic test_sequential();
    instr_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin
        errors++; $display("FAIL wait_ack got req=%b addr=%h valid=%b exp 1 00000000 0", imem_req, imem_addr, instr_valid);
      end
    end
    ack_with(32'hA000_0000);
    checks++;
    if (instr_valid !== 1'b1 || pc_out !== 32'h0 || instr !== 32'hA000_0000 || imem_req !== 1'b0) begin
      errors++; $display("FAIL seq0 got valid=%b pc=%h instr=%h req=%b exp 1 00000000 a0000000 0", instr_valid, pc_out, instr, imem_req);
    end
    step();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h4 || instr_valid !== 1'b0) begin
      errors++; $display("FAIL addr4 got req=%b addr=%h valid=%b exp 1 00000004 0", imem_req, imem_addr, instr_valid);
    end
    ack_with(32'hA000_0004);
    checks++;
    if (instr_valid !== 1'b1 || pc_out !== 32'h4 || instr !== 32'hA000_0004) begin
      errors++; $display("FAIL seq4 got valid=%b pc=%h instr=%h exp 1 00000004 a0000004", instr_valid, pc_out, instr);
    end
    step();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin
      errors++; $display("FAIL addr8 got req=%b addr=%h exp 1 00000008", imem_req, imem_addr);
    end
    instr_ready = 1'b0;
    ack_with(32'hA000_0008);
    checks++;
    if (instr_valid !== 1'b1 || pc_out !== 32'h8 || instr !== 32'hA000_0008) begin
      errors++; $display("FAIL seq8 got valid=%b pc=%h instr=%h exp 1 00000008 a0000008", instr_valid, pc_out, instr);
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (instr_valid !== 1'b1 || pc_out !== 32'h8 || instr !== 32'hA000_0008 || imem_req !== 1'b0) begin
        errors++; $display("FAIL stall[%0d] got valid=%b pc=%h instr=%h req=%b exp 1 00000008 a0000008 0", i, instr_valid, pc_out, instr, imem_req);
      end
    end
    instr_ready = 1'b1;
    step();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin
      errors++; $display("FAIL after_stall got req=%b addr=%h exp 1 0000000c", imem_req, imem_addr);
    end
    ack_with(32'hA000_000C);
    step();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin
      errors++; $display("FAIL addr10 got req=%b addr=%h exp 1 00000010", imem_req, imem_addr);
    end
  endtask

  task automatic test_kill();
    redirect = 1'b1;
    nextpc   = 32'h0000_0103;
    step();
    redirect = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (imem_addr !== 32'h10 || imem_req !== 1'b1 || instr_valid !== 1'b0) begin
        errors++; $display("FAIL kill_hold[%0d] got addr=%h req=%b valid=%b exp 00000010 1 0", i, imem_addr, imem_req, instr_valid);
      end
      step();
    end
    ack_with(32'hDEAD_BEEF);
    checks++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      errors++; $display("FAIL kill_drop got valid=%b req=%b addr=%h exp 0 1 00000100", instr_valid, imem_req, imem_addr);
    end
    step();
    checks++;
    if (instr_valid !== 1'b0 || imem_addr !== 32'h100 || instr === 32'hDEAD_BEEF) begin
      errors++; $display("FAIL kill_quiet got valid=%b addr=%h instr=%h exp 0 00000100 not deadbeef", instr_valid, imem_addr, instr);
    end
  endtask

  task automatic test_double_redirect();
    redirect = 1'b1;
    nextpc   = 32'h0000_0200;
    step();
    nextpc   = 32'h0000_0300;
    step();
    redirect = 1'b0;
    step();
    ack_with(32'h1111_1111);
    checks++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h300) begin
      errors++; $display("FAIL newest_wins got valid=%b req=%b addr=%h exp 0 1 00000300", instr_valid, imem_req, imem_addr);
    end
    // Ack arriving with a same-cycle redirect: data dropped, new target taken.
    redirect = 1'b1;
    nextpc   = 32'h0000_0008;
    ack_with(32'h2222_2222);
    redirect = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || imem_addr !== 32'h8) begin
      errors++; $display("FAIL ack_redirect got valid=%b addr=%h exp 0 00000008", instr_valid, imem_addr);
    end
  endtask

  task automatic test_back_to_back();
    instr_ready = 1'b0;
    ack_with(32'h8888_0008);
    checks++;
    if (instr_valid !== 1'b1 || pc_out !== 32'h8 || instr !== 32'h8888_0008) begin
      errors++; $display("FAIL b2b_valid got valid=%b pc=%h instr=%h exp 1 00000008 88880008", instr_valid, pc_out, instr);
    end
    xfer_count  = 0;
    instr_ready = 1'b1;
    redirect    = 1'b1;
    nextpc      = 32'h0000_0040;
    step();
    redirect    = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h40) begin
      errors++; $display("FAIL b2b_next got valid=%b req=%b addr=%h exp 0 1 00000040", instr_valid, imem_req, imem_addr);
    end
    step();
    step();
    checks++;
    if (xfer_count !== 1 || last_xfer_pc !== 32'h8) begin
      errors++; $display("FAIL b2b_once got count=%0d pc=%h exp 1 00000008", xfer_count, last_xfer_pc);
    end
  endtask

  task automatic test_wrap_and_reset();
    instr_ready = 1'b0;
    ack_with(32'h4444_0040);
    redirect = 1'b1;
    nextpc   = 32'hFFFF_FFFE;
    step();
    redirect = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL redirect_noready got valid=%b req=%b addr=%h exp 0 1 fffffffc", instr_valid, imem_req, imem_addr);
    end
    ack_with(32'hFFFF_0000);
    checks++;
    if (instr_valid !== 1'b1 || pc_out !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL top_valid got valid=%b pc=%h exp 1 fffffffc", instr_valid, pc_out);
    end
    instr_ready = 1'b1;
    step();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++; $display("FAIL wrap got req=%b addr=%h exp 1 00000000", imem_req, imem_addr);
    end
    nextpc   = 32'h0000_0500;
    redirect = 1'b1;
    step();
    redirect = 1'b0;
    rst      = 1'b1;
    step();
    checks++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0 || imem_addr !== 32'h0 || pc_out !== 32'h0) begin
      errors++; $display("FAIL midfetch_rst got req=%b valid=%b addr=%h pc=%h exp 0 0 00000000 00000000", imem_req, instr_valid, imem_addr, pc_out);
    end
    rst = 1'b0;
    ack_with(32'h5555_5555);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin
      errors++; $display("FAIL late_ack got req=%b addr=%h valid=%b exp 1 00000000 0", imem_req, imem_addr, instr_valid);
    end
    step();
    checks++;
    if (instr_valid !== 1'b0 || imem_addr !== 32'h0) begin
      errors++; $display("FAIL no_kill_left got valid=%b addr=%h exp 0 00000000", instr_valid, imem_addr);
    end
    instr_ready = 1'b0;
    ack_with(32'h6666_0000);
    checks++;
    if (instr_valid !== 1'b1 || pc_out !== 32'h0 || instr !== 32'h6666_0000) begin
      errors++; $display("FAIL refetch got valid=%b pc=%h instr=%h exp 1 00000000 66660000", instr_valid, pc_out, instr);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_kill();
    test_double_redirect();
    test_back_to_back();
    test_wrap_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
